// File: rtl/line_reader_pkg.sv
// Shared types and constants for the line reader: FSM state encoding,
// line/word geometry and the line tag type.
package line_reader_pkg;

    localparam int LINE_WIDTH = 256;
    localparam int WORD_WIDTH = 32;
    localparam int TAG_WIDTH  = 27;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } line_reader_state_t;

    typedef logic [LINE_WIDTH-1:0] line_t;
    typedef logic [TAG_WIDTH-1:0]  line_tag_t;

    // Line tag of a CPU byte address (upper 27 bits).
    function automatic line_tag_t tag_of(input logic [31:0] addr);
        return addr[31:5];
    endfunction

endpackage

// File: rtl/line_reader_if.sv
// Bundles the CPU read port, the cache data-array fetch port and the
// invalidate snoop. The slave side is the line reader itself; the master
// side is whoever drives the CPU requests, line responses and snoops.
interface line_reader_if;
    import line_reader_pkg::*;

    // CPU memory port
    logic        mem_read;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    // Cache data-array fetch port
    logic        line_read;
    line_tag_t   line_address;
    logic        line_resp;
    line_t       line_rdata;

    // Invalidate snoop from the write path
    logic        inval;
    line_tag_t   inval_address;

    modport slave (
        input  mem_read, mem_address, mem_byte_enable,
        output mem_rdata, mem_resp,
        output line_read, line_address,
        input  line_resp, line_rdata,
        input  inval, inval_address
    );

    modport master (
        output mem_read, mem_address, mem_byte_enable,
        input  mem_rdata, mem_resp,
        input  line_read, line_address,
        output line_resp, line_rdata,
        output inval, inval_address
    );

endinterface

// File: rtl/line_word_extract.sv
// Selects one 32-bit word out of a 256-bit line and zeroes every byte lane
// whose enable bit is clear. Purely combinational.
module line_word_extract
    import line_reader_pkg::*;
(
    input  line_t       line,
    input  logic [2:0]  sel,
    input  logic [3:0]  byte_enable,
    output logic [31:0] word
);

    logic [WORD_WIDTH-1:0] raw_word;

    // Word k lives at bits [32k+31:32k]; all eight words are reachable.
    assign raw_word = line[WORD_WIDTH*sel +: WORD_WIDTH];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word[8*gi +: 8] = byte_enable[gi] ? raw_word[8*gi +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/line_reader.sv
// One-line read buffer in front of the cache data array. Hits are answered
// from the buffer; misses fetch the whole line, fill the buffer and answer
// from the fetched data. The write path's invalidate snoop keeps the buffer
// coherent and always wins over a hit in the same cycle.
module line_reader
    import line_reader_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    line_reader_if.slave     bus
);

    line_reader_state_t state_reg;

    logic        buf_valid_reg;
    line_tag_t   buf_tag_reg;
    line_t       buf_data_reg;

    line_tag_t   req_tag_reg;
    logic [2:0]  req_sel_reg;
    logic [3:0]  req_be_reg;

    logic [31:0] mem_rdata_reg;
    logic        mem_resp_reg;
    logic        line_read_reg;

    logic [31:0] hit_word;
    logic [31:0] fill_word;
    logic        inval_buf_match;
    logic        inval_req_match;
    logic        hit;

    // Byte offset bits carry no information for word reads.
    logic        unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.mem_address[1:0]};

    // Hit path extracts from the buffer using the live CPU request.
    line_word_extract u_hit_extract (
        .line        (buf_data_reg),
        .sel         (bus.mem_address[4:2]),
        .byte_enable (bus.mem_byte_enable),
        .word        (hit_word)
    );

    // Fill path extracts from the incoming line using the captured request.
    line_word_extract u_fill_extract (
        .line        (bus.line_rdata),
        .sel         (req_sel_reg),
        .byte_enable (req_be_reg),
        .word        (fill_word)
    );

    assign inval_buf_match = bus.inval && (bus.inval_address == buf_tag_reg);
    assign inval_req_match = bus.inval && (bus.inval_address == req_tag_reg);

    // A snoop against the buffered line turns a would-be hit into a miss.
    assign hit = bus.mem_read && buf_valid_reg &&
                 (buf_tag_reg == tag_of(bus.mem_address)) && !inval_buf_match;

    // Request FSM plus the buffer and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
            buf_data_reg  <= '0;
            req_tag_reg   <= '0;
            req_sel_reg   <= '0;
            req_be_reg    <= '0;
            mem_rdata_reg <= '0;
            mem_resp_reg  <= 1'b0;
            line_read_reg <= 1'b0;
        end else begin
            // Snoop clears the buffer in every state; a fill below overrides
            // this with its own check against the newly installed tag.
            if (inval_buf_match) begin
                buf_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        mem_rdata_reg <= hit_word;
                        mem_resp_reg  <= 1'b1;
                        state_reg     <= RESP;
                    end else if (bus.mem_read) begin
                        req_tag_reg   <= tag_of(bus.mem_address);
                        req_sel_reg   <= bus.mem_address[4:2];
                        req_be_reg    <= bus.mem_byte_enable;
                        line_read_reg <= 1'b1;
                        state_reg     <= FETCH;
                    end
                end

                FETCH: begin
                    // Not abortable: completes even if mem_read has dropped.
                    if (bus.line_resp) begin
                        buf_data_reg  <= bus.line_rdata;
                        buf_tag_reg   <= req_tag_reg;
                        buf_valid_reg <= !inval_req_match;
                        mem_rdata_reg <= fill_word;
                        mem_resp_reg  <= 1'b1;
                        line_read_reg <= 1'b0;
                        state_reg     <= RESP;
                    end
                end

                RESP: begin
                    mem_resp_reg <= 1'b0;
                    state_reg    <= IDLE;
                end

                default: begin
                    mem_resp_reg  <= 1'b0;
                    line_read_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rdata    = mem_rdata_reg;
    assign bus.mem_resp     = mem_resp_reg;
    assign bus.line_read    = line_read_reg;
    assign bus.line_address = req_tag_reg;

endmodule

// File: tb/tb_line_reader.sv
// Directed bench for line_reader: a scoreboard queue gets the expected read
// data when a request is issued; a monitor pops it whenever mem_resp is seen.
module tb_line_reader;
    import line_reader_pkg::*;

    logic clk;
    logic reset_n;

    line_reader_if bus();

    line_reader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    logic [31:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%08h at %0t", name, act, $time);
        end
    endtask

    function automatic line_t make_line(input logic [31:0] base);
        line_t l;
        for (int k = 0; k < 8; k++) begin
            l[32*k +: 32] = base + 32'(k);
        end
        return l;
    endfunction

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && bus.mem_resp) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got mem_resp=1 rdata=0x%08h expected no response at %0t",
                         bus.mem_rdata, $time);
            end else begin
                check("resp_data", bus.mem_rdata, sb_q.pop_front());
            end
        end
    end

    // One CPU read. For a miss, line_resp is returned in the last of
    // fetch_cycles FETCH cycles; optional snoops on the request/response cycle.
    task automatic read_access(input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] exp, input bit miss,
                               input int fetch_cycles, input logic [31:0] base,
                               input bit inval_on_req, input bit inval_on_resp);
        @(posedge clk); #1;
        bus.mem_read        = 1'b1;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        if (inval_on_req) begin
            bus.inval         = 1'b1;
            bus.inval_address = addr[31:5];
        end
        sb_q.push_back(exp);
        @(posedge clk); #1;
        bus.inval = 1'b0;
        if (!miss) begin
            check("hit_resp_n1", 32'(bus.mem_resp), 32'd1);
            check("hit_no_line_read", 32'(bus.line_read), 32'd0);
            bus.mem_read = 1'b0;
        end else begin
            for (int c = 1; c <= fetch_cycles; c++) begin
                check("fetch_line_read", 32'(bus.line_read), 32'd1);
                check("fetch_line_addr", 32'(bus.line_address), 32'(addr[31:5]));
                check("fetch_no_resp", 32'(bus.mem_resp), 32'd0);
                if (c == fetch_cycles) begin
                    bus.line_resp  = 1'b1;
                    bus.line_rdata = make_line(base);
                    if (inval_on_resp) begin
                        bus.inval         = 1'b1;
                        bus.inval_address = addr[31:5];
                    end
                end
                @(posedge clk); #1;
            end
            bus.line_resp = 1'b0;
            bus.inval     = 1'b0;
            bus.mem_read  = 1'b0;
            check("miss_resp_m1", 32'(bus.mem_resp), 32'd1);
            check("miss_line_read_low", 32'(bus.line_read), 32'd0);
        end
        @(posedge clk); #1;
        check("resp_one_cycle", 32'(bus.mem_resp), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] addr;
        checks = 0;
        errors = 0;
        bus.mem_read        = 1'b0;
        bus.mem_address     = '0;
        bus.mem_byte_enable = '0;
        bus.line_resp       = 1'b0;
        bus.line_rdata      = '0;
        bus.inval           = 1'b0;
        bus.inval_address   = '0;
        reset_n             = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_resp", 32'(bus.mem_resp), 32'd0);
        check("rst_line_read", 32'(bus.line_read), 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
        reset_n = 1'b1;

        // Reset mid-FETCH: outputs clear immediately, late line_resp ignored.
        @(posedge clk); #1;
        bus.mem_read = 1'b1; bus.mem_address = 32'h0000_0040; bus.mem_byte_enable = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_line_read", 32'(bus.line_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_line_read", 32'(bus.line_read), 32'd0);
        check("async_rst_mem_resp", 32'(bus.mem_resp), 32'd0);
        check("async_rst_mem_rdata", bus.mem_rdata, 32'd0);
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.line_resp = 1'b1; bus.line_rdata = make_line(32'hDEAD_0000);
        @(posedge clk); #1;
        bus.line_resp = 1'b0;
        check("post_rst_no_resp", 32'(bus.mem_resp), 32'd0);
        @(posedge clk); #1;
        check("post_rst_no_resp2", 32'(bus.mem_resp), 32'd0);

        // Cold miss, 3 FETCH cycles, word 5.
        read_access(32'h0000_1014, 4'b1111, 32'hA0A0_0005, 1'b1, 3, 32'hA0A0_0000, 1'b0, 1'b0);
        // Hits with masking.
        read_access(32'h0000_101C, 4'b0010, 32'h0000_0000, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        read_access(32'h0000_1000, 4'b1100, 32'hA0A0_0000, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        read_access(32'h0000_1018, 4'b0001, 32'h0000_0006, 1'b0, 0, 32'h0, 1'b0, 1'b0);

        // Invalidate race: snoop on request turns hit into miss; snoop on
        // line_resp still answers with fetched data but leaves buffer invalid.
        read_access(32'h0000_1008, 4'b1111, 32'hA0A0_0002, 1'b1, 1, 32'hA0A0_0000, 1'b1, 1'b1);
        read_access(32'h0000_100C, 4'b1111, 32'hA0A0_0003, 1'b1, 2, 32'hA0A0_0000, 1'b0, 1'b0);

        // Tag change and word 7, then the old line misses again.
        read_access(32'h0000_2FFC, 4'b1111, 32'hB0B0_0007, 1'b1, 1, 32'hB0B0_0000, 1'b0, 1'b0);
        read_access(32'h0000_1000, 4'b1111, 32'hA0A0_0000, 1'b1, 2, 32'hA0A0_0000, 1'b0, 1'b0);

        // Back-to-back hits, sel 0..7, CPU re-requests during each RESP cycle.
        @(posedge clk); #1;
        bus.mem_read = 1'b1; bus.mem_byte_enable = 4'hF;
        bus.mem_address = 32'h0000_1000;
        sb_q.push_back(32'hA0A0_0000);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("b2b_resp", 32'(bus.mem_resp), 32'd1);
            check("b2b_no_line_read", 32'(bus.line_read), 32'd0);
            if (k < 7) begin
                addr = 32'h0000_1000 + 32'(4 * (k + 1));
                bus.mem_address = addr;
                sb_q.push_back(32'hA0A0_0000 + 32'(k + 1));
            end else begin
                bus.mem_read = 1'b0;
            end
            @(posedge clk); #1;
            check("b2b_gap", 32'(bus.mem_resp), 32'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_reader.md
# line_reader

Read-side counterpart of the cache write-merge path: serves CPU word reads out of 256-bit cache lines. Holds a one-line read buffer. On a buffer hit it answers from the buffer. On a miss it fetches the line from the cache data array over a request/response handshake, captures it, then answers. Sits between the CPU memory port and the cache datapath; the write path's invalidate snoop keeps the buffer coherent.

## Interface
- No parameters: line width is 256, word width is 32, line tag is address[31:5]; all fixed in rv32i_types.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU read request; held high until mem_resp.
- mem_address  in  32  CPU byte address. [31:5] is the tag, [4:2] is the word select, [1:0] is ignored.
- mem_byte_enable  in  4  requested byte lanes; unrequested lanes return 0.
- mem_rdata  out  32  registered read data, valid when mem_resp=1.
- mem_resp  out  1  one-cycle response pulse.
- line_read  out  1  line fetch request to the cache data array.
- line_address  out  27  tag of the line being fetched.
- line_resp  in  1  fetch complete; line_rdata is valid this cycle.
- line_rdata  in  256  fetched line; word k occupies bits [32k+31:32k].
- inval  in  1  write path modified a line.
- inval_address  in  27  tag of the modified line.

## Operation
- State: buf_valid, buf_tag[26:0], buf_data[255:0], req_tag[26:0], req_sel[2:0], req_be[3:0], and an FSM with states IDLE, FETCH, RESP.
- **Extraction.** word = line[32*sel +: 32]. All 8 words are selectable. Byte lane i of the result is word[8i+7:8i] if be[i] is set, else 0. Any enable pattern is legal.
- **IDLE.**
  - A hit is mem_read=1 && buf_valid && buf_tag==mem_address[31:5] && !(inval && inval_address==buf_tag).
  - On a hit: load mem_rdata = extract(buf_data, mem_address[4:2], mem_byte_enable), then go to RESP.
  - On mem_read=1 with no hit: capture req_tag, req_sel and req_be, then go to FETCH.
- **FETCH.**
  - line_read=1 and line_address=req_tag throughout.
  - On line_resp=1: buf_data←line_rdata, buf_tag←req_tag, buf_valid←1, mem_rdata←extract(line_rdata, req_sel, req_be), then go to RESP.
  - The fetch cannot be aborted. If mem_read drops mid-fetch, the fetch still completes and mem_resp still pulses.
- **RESP.** mem_resp=1 for exactly one cycle, then go to IDLE unconditionally. mem_read is not sampled in RESP.
- **Invalidate.**
  - In any state, inval && inval_address==buf_tag clears buf_valid on that edge.
  - Invalidate has priority over the hit check in the same cycle.
  - If inval matches req_tag in the same cycle as line_resp, the response still uses the fetched data, but buf_valid ends at 0.
- **Ignored inputs.** line_resp in IDLE or RESP is ignored.

## Timing
- **Reset values.** reset_n=0 asynchronously forces:
  - state IDLE, buf_valid 0, buf_tag 0, buf_data 0;
  - mem_rdata 0, mem_resp 0, line_read 0.
  - Reset mid-FETCH drops line_read immediately. A line_resp arriving after reset is ignored.
- **Outputs are registered or Moore.** mem_resp, line_read and line_address depend on state only. mem_rdata holds its value until the next load.
- **Hit latency.** mem_read is sampled at edge N in IDLE; mem_resp is high during cycle N+1.
- **Miss latency.**
  - line_read rises in cycle N+1.
  - line_resp is sampled at edge M; mem_resp is high during cycle M+1 and line_read is low in M+1.
  - Minimum miss latency is 2 cycles, reached when line_resp arrives in the first FETCH cycle.
- **Back-to-back requests.** A new request may be sampled at the first IDLE edge after RESP. This gives a sustained hit throughput of one access per 2 cycles.

## Structure
- rv32i_types gains:
  - line_reader_state_t, an enum of IDLE, FETCH and RESP;
  - LINE_WIDTH=256 and WORD_WIDTH=32;
  - typedef line_t (logic [255:0]) and typedef line_tag_t (logic [26:0]).
- One combinational sub-module, line_word_extract: inputs line, sel and byte_enable; output the masked 32-bit word. It is instantiated twice, once on buf_data for the hit path and once on line_rdata for the fill path, or once behind a mux.

## Test plan
- **Reset:** assert reset_n=0 mid-FETCH → line_read, mem_resp and mem_rdata are 0 immediately. Release reset, then pulse line_resp → no mem_resp.
- **Cold miss:** mem_read with addr 0x0000_1014 and be=1111; line_resp 3 cycles later with word k=0xA0A0_0000+k → mem_rdata=0xA0A0_0005 and mem_resp in the cycle after line_resp. Checks: line_address=0x80 during FETCH; line_read is held for all 3 FETCH cycles.
- **Hit with masking:** after the cold miss, read 0x0000_101C with be=0010 → mem_rdata=0x0000_0000|(0xA0A0_0007 & 0x0000_FF00)=0x0000_0000, and read 0x0000_1000 with be=1100 → 0xA0A0_0000. Both respond 1 cycle after the request, with no line_read.
- **Invalidate race:** inval with inval_address=0x80 in the same cycle as a hit request to 0x0000_1008 → treated as a miss, line_read asserted. If inval repeats on the line_resp cycle → the response is correct and the next read to the same line misses again.
- **Tag change and word 7:** read 0x0000_2FFC after the line at 0x1000 is buffered → miss to tag 0x17F, returns line word 7 (bits [255:224]). A following read to 0x0000_1000 misses.
- **Back-to-back:** 8 consecutive hits covering sel 0..7 with CPU re-requesting immediately → mem_resp every other cycle, each word correct.
